uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, 8N1, LSB first, idle-high line, the receive counterpart of the board's UART transmitter. Oversamples the asynchronous rx pin with the system clock. Validates the start bit at mid-bit, samples each data bit at bit centre and checks the stop bit. Presents each received byte on a held valid/ack handshake to the consuming logic (display/command decoder).

Parameters:
CLKS_PER_BIT, 10416, system clocks per bit (100 MHz / 9600 bps); legal range 4..65535
HALF_BIT, CLKS_PER_BIT/2, clocks from start-edge detect to start-bit centre sample

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
rx  input  1  serial line from pin, asynchronous, idle high
data_out  output  8  last received byte; stable while data_valid=1
data_valid  output  1  high from byte completion until data_ack accepted
data_ack  input  1  consumer acknowledge; clears data_valid on the cycle after it is sampled high
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  sticky: byte completed while data_valid already 1; cleared by data_ack
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: data_out=8'h00, data_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, counters 0, synchroniser flops=1.
- rx passes through a 2-flop synchroniser (rx_s). Edge detection and sampling use rx_s only. This adds 2 cycles of latency from the pin.
- Counter clk_cnt is 16 bits. Bit index bit_idx is 3 bits (0..7).
- IDLE: when rx_s=0, go to START with clk_cnt=0.
- START: clk_cnt counts to HALF_BIT-1.
  - If rx_s=1 at that sample, the start was a glitch: return to IDLE, no output.
  - Otherwise go to DATA with clk_cnt=0 and bit_idx=0.
- DATA: on each clk_cnt==CLKS_PER_BIT-1, shift rx_s into the shift register MSB, so the first bit received ends in bit 0. Then reset clk_cnt and increment bit_idx. After bit_idx==7 is sampled, go to STOP.
- STOP: at clk_cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1: data_out<=shift register. data_valid<=1. If data_valid was already 1 and is not being acked this cycle, overrun<=1 and data_out is still overwritten with the new byte.
  - rx_s=0: frame_err pulses for 1 cycle, data_out and data_valid are unchanged, and no byte is delivered.
  - Either way go to IDLE. A line held low after a framing error must return high before a new start is detected: IDLE waits for rx_s=1 at least once after a frame error.
- Latency: data_valid rises exactly 2 + HALF_BIT + 9*CLKS_PER_BIT cycles (±1) after the falling edge on rx.
- Handshake: data_ack high while data_valid=1 clears data_valid and overrun next cycle. data_ack while data_valid=0 is ignored. If ack and a new-byte completion coincide, completion wins: data_valid stays 1 with the new byte and overrun is not set.
- Reset asserted mid-frame aborts immediately to IDLE. After release, a partially observed frame is treated as line noise: wait for rx_s=1 before arming.
- busy=1 from START entry through the STOP sample cycle.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding: IDLE, START, DATA, STOP
  - DATA_BITS=8
  - default CLKS_PER_BIT for 100 MHz / 9600
  - the same constant is reused by the transmitter
- One natural sub-module: uart_rx_sync, the 2-flop synchroniser with reset-to-1. The FSM, counters and handshake stay in uart_rx.

Test Plan:
1. CLKS_PER_BIT=16: send 8'hA5 with correct framing -> data_out=8'hA5, data_valid=1 at 2+8+144 cycles ±1, frame_err=0, busy low afterwards.
2. Send 8'h3C, hold data_ack=0, then send 8'hC3 -> data_out=8'hC3, overrun=1. Pulse data_ack -> data_valid=0 and overrun=0 next cycle.
3. Send 8'h55 with the stop bit driven low -> frame_err pulses one cycle, data_valid stays 0, data_out keeps its previous value. Hold rx low 40 cycles then high -> no spurious byte. A following 8'h0F is received correctly.
4. Glitch rx low for 4 cycles (less than HALF_BIT) -> returns to IDLE, busy falls, no data_valid. A following 8'hFF is received correctly.
5. Assert reset during bit 3 of 8'h81 -> all outputs at reset values. After release the rest of the frame yields no byte. A subsequent 8'h7E arrives as 8'h7E.
6. Back-to-back frames 8'h00, 8'hFF, 8'h5A with one stop bit each and data_ack asserted the cycle after each data_valid -> three bytes in order, no overrun, no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receiver and the transmitter.
//   DATA_BITS            : payload bits per frame (8N1)
//   CLKS_PER_BIT_DEFAULT : system clocks per bit for 100 MHz / 9600 bps
//   uart_state_t         : receiver FSM state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 10416;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for the asynchronous serial input. Both flops reset
// to 1 so the synchronised line looks idle (high) while reset is applied.
// Ports:
//   i_clk   : system clock
//   i_reset : asynchronous active-high reset
//   i_async : asynchronous serial line from the pin
//   o_sync  : synchronised line, 2 clocks behind the pin
// -----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep this a two-stage shift; blocking
      // ones would collapse both flops into a single stage.
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, idle-high line. Start bit is validated at its
// centre, data bits are sampled at bit centre, stop bit is checked. Received
// bytes are held on a valid/ack handshake.
// Ports:
//   i_clk        : system clock, all logic on rising edge
//   i_reset      : asynchronous active-high reset, clears all state
//   i_rx         : serial line from pin (asynchronous, idle high)
//   o_data_out   : last received byte, stable while o_data_valid=1
//   o_data_valid : high from byte completion until i_data_ack is accepted
//   i_data_ack   : consumer acknowledge
//   o_frame_err  : one-cycle pulse when the stop bit is sampled low
//   o_overrun    : sticky, byte completed while o_data_valid already high
//   o_busy       : high in any state other than IDLE
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data_out,
  output logic                 o_data_valid,
  input  logic                 i_data_ack,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int          HALF_BIT    = CLKS_PER_BIT / 2;
  localparam logic [15:0] C_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] C_HALF_LAST = 16'(HALF_BIT - 1);
  localparam logic [2:0]  C_IDX_LAST  = 3'(DATA_BITS - 1);

  logic                 w_rx_s;
  uart_state_t          r_state;
  logic [15:0]          r_clk_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_data_valid;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 r_busy;
  // Start detection is only armed once the line has been seen high. r_flush
  // skips the synchroniser's reset-value ones, so a frame that was already in
  // flight at reset release is not mistaken for an idle line.
  logic                 r_armed;
  logic [1:0]           r_flush;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_rx),
    .o_sync  (w_rx_s)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
      r_armed      <= 1'b0;
      r_flush      <= '0;
    end else begin
      r_frame_err <= 1'b0;

      if (r_flush != 2'd2) begin
        r_flush <= r_flush + 2'd1;
      end

      // Consumer handshake. A byte completing in the same cycle is assigned
      // further down and therefore takes precedence over this clear.
      if (r_data_valid && i_data_ack) begin
        r_data_valid <= 1'b0;
        r_overrun    <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_clk_cnt <= '0;
          if (!r_armed) begin
            if (w_rx_s && (r_flush == 2'd2)) begin
              r_armed <= 1'b1;
            end
          end else if (!w_rx_s) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end

        START: begin
          if (r_clk_cnt == C_HALF_LAST) begin
            r_clk_cnt <= '0;
            if (w_rx_s) begin
              // Line back high at the start-bit centre: a glitch, not a frame.
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= DATA;
              r_bit_idx <= '0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end

        DATA: begin
          if (r_clk_cnt == C_BIT_LAST) begin
            r_clk_cnt <= '0;
            // LSB arrives first, so shifting in at the MSB leaves it in bit 0.
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == C_IDX_LAST) begin
              r_state <= STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end

        STOP: begin
          if (r_clk_cnt == C_BIT_LAST) begin
            r_clk_cnt <= '0;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            if (w_rx_s) begin
              r_data_out   <= r_shift;
              r_data_valid <= 1'b1;
              if (r_data_valid && !i_data_ack) begin
                r_overrun <= 1'b1;
              end
            end else begin
              // Line may be held low (break); require it high before re-arming.
              r_frame_err <= 1'b1;
              r_armed     <= 1'b0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;
  assign o_busy       = r_busy;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx at CLKS_PER_BIT=16. Expected bytes are queued
// when a frame is sent; a monitor pops and compares each delivered byte.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  typedef struct packed {
    logic [7:0] data;
    logic       ovr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   got = 0;
  int   fe_count = 0;
  int   last_valid_cyc = 0;
  int   cyc = 0;
  int   t_fall = 0;
  bit   auto_ack = 1'b1;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_rx         (rx),
    .o_data_out   (data_out),
    .o_data_valid (data_valid),
    .i_data_ack   (data_ack),
    .o_frame_err  (frame_err),
    .o_overrun    (overrun),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the whole stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    t_fall = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_bytes(input int target, input int bound);
    int k;
    k = 0;
    while (got < target && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (got < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_bytes: got %0d bytes expected %0d", got, target);
    end
  endtask

  // Scoreboard monitor: a new byte is a rising data_valid, or an overrun
  // rising while data_valid is already held.
  initial begin
    logic pv;
    logic po;
    logic pf;
    exp_t e;
    pv = 1'b0;
    po = 1'b0;
    pf = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (data_valid && (!pv || (overrun && !po))) begin
          got++;
          last_valid_cyc = cyc;
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %02h expected none", data_out);
          end else begin
            e = sb_q.pop_front();
            check("sb_data", {24'd0, data_out}, {24'd0, e.data});
            check("sb_overrun", {31'd0, overrun}, {31'd0, e.ovr});
          end
        end
        if (frame_err && !pf) fe_count++;
        if (pf) check("frame_err_one_cycle", {31'd0, frame_err}, 32'd0);
      end
      pv = data_valid;
      po = overrun;
      pf = frame_err;
    end
  end

  // Automatic consumer: acknowledge the cycle after data_valid is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack) data_ack = data_valid && !data_ack;
    end
  end

  initial begin
    int lat;
    int fe0;

    repeat (3) @(negedge clk);
    check("rst_data_out", {24'd0, data_out}, 32'h00);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    // 1: single byte, latency 2 + HALF_BIT + 9*CPB (+-1)
    sb_q.push_back('{data: 8'hA5, ovr: 1'b0});
    send_frame(8'hA5, 1'b1);
    wait_bytes(1, 50);
    lat = last_valid_cyc - t_fall;
    check("t1_latency", (lat >= 153 && lat <= 155) ? 32'd154 : lat, 32'd154);
    check("t1_data_out", {24'd0, data_out}, 32'hA5);
    check("t1_busy_low", {31'd0, busy}, 32'd0);
    check("t1_no_frame_err", fe_count, 32'd0);

    // 2: overrun when second byte arrives unacknowledged
    auto_ack = 1'b0;
    sb_q.push_back('{data: 8'h3C, ovr: 1'b0});
    send_frame(8'h3C, 1'b1);
    sb_q.push_back('{data: 8'hC3, ovr: 1'b1});
    send_frame(8'hC3, 1'b1);
    wait_bytes(3, 50);
    check("t2_data_out", {24'd0, data_out}, 32'hC3);
    check("t2_overrun", {31'd0, overrun}, 32'd1);
    check("t2_valid", {31'd0, data_valid}, 32'd1);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check("t2_valid_cleared", {31'd0, data_valid}, 32'd0);
    check("t2_overrun_cleared", {31'd0, overrun}, 32'd0);
    auto_ack = 1'b1;

    // 3: framing error, line held low, then a good byte
    fe0 = fe_count;
    send_frame(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("t3_frame_err_pulse", fe_count, fe0 + 1);
    check("t3_valid_low", {31'd0, data_valid}, 32'd0);
    check("t3_data_kept", {24'd0, data_out}, 32'hC3);
    check("t3_no_spurious", got, 32'd3);
    sb_q.push_back('{data: 8'h0F, ovr: 1'b0});
    send_frame(8'h0F, 1'b1);
    wait_bytes(4, 50);

    // 4: short glitch on the line
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_busy_in_start", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_busy_fell", {31'd0, busy}, 32'd0);
    check("t4_no_byte", got, 32'd4);
    sb_q.push_back('{data: 8'hFF, ovr: 1'b0});
    send_frame(8'hFF, 1'b1);
    wait_bytes(5, 50);
    check("t4_data_ff", {24'd0, data_out}, 32'hFF);

    // 5: reset in the middle of bit 3
    fork
      send_frame(8'h81, 1'b1);
      begin
        repeat (72) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_rst_data_out", {24'd0, data_out}, 32'h00);
        check("t5_rst_valid", {31'd0, data_valid}, 32'd0);
        check("t5_rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("t5_rst_overrun", {31'd0, overrun}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
      end
    join
    repeat (40) @(negedge clk);
    check("t5_no_byte", got, 32'd5);
    check("t5_busy_low", {31'd0, busy}, 32'd0);
    sb_q.push_back('{data: 8'h7E, ovr: 1'b0});
    send_frame(8'h7E, 1'b1);
    wait_bytes(6, 50);
    check("t5_data_7e", {24'd0, data_out}, 32'h7E);

    // 6: back-to-back frames with prompt acknowledge
    fe0 = fe_count;
    sb_q.push_back('{data: 8'h00, ovr: 1'b0});
    sb_q.push_back('{data: 8'hFF, ovr: 1'b0});
    sb_q.push_back('{data: 8'h5A, ovr: 1'b0});
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    wait_bytes(9, 50);
    repeat (4) @(negedge clk);
    check("t6_no_frame_err", fe_count, fe0);
    check("t6_overrun_low", {31'd0, overrun}, 32'd0);
    check("t6_busy_low", {31'd0, busy}, 32'd0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx
